// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state/round types and constants
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int BLK_W = 132;
  typedef logic [0:127] state_t;
  typedef logic [3:0] round_t;
endpackage

// File: rtl/ark_skid_buf.sv
// ark_skid_buf: 2-entry skid register (output register plus one overflow slot)
module ark_skid_buf
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [BLK_W-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BLK_W-1:0] out_data,
  output logic             skid_full
);
  logic [BLK_W-1:0] skid_data;
  logic pop;
  assign pop = out_valid & out_ready;
  // skid slot fills only when the output register is occupied and not draining
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else if (skid_full) begin
      if (pop) begin
        out_data  <= skid_data;
        skid_full <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid || pop) begin
        out_data  <= push_data;
        out_valid <= 1'b1;
      end else begin
        skid_data <= push_data;
        skid_full <= 1'b1;
      end
    end else if (pop) out_valid <= 1'b0;
endmodule

// File: rtl/add_round_key_stage.sv
// add_round_key_stage: registered AES AddRoundKey with valid/ready handshake
// ARK_SKID_BUFFER_EN selects a 2-entry skid buffer instead of a single output register
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [0:127] in_key,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic [3:0]   out_round,
  output logic         out_final,
  output logic         err_round
);
  logic rst_q, accept;
  logic [BLK_W-1:0] blk_in, blk_out;
  assign accept = in_valid & in_ready;
  assign blk_in = {in_round, in_state ^ in_key};
  assign {out_round, out_state} = blk_out;
  assign out_final = out_round == round_t'(NR);
  // rst_q keeps in_ready low through the reset cycle without a path from out_ready
  always_ff @(posedge clk) begin
    rst_q <= rst;
    err_round <= rst ? 1'b0 : err_round | (accept & (in_round > round_t'(NR)));
  end
`ifdef ARK_SKID_BUFFER_EN
  logic skid_full;
  ark_skid_buf u_buf (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .push_data(blk_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(blk_out),
    .skid_full(skid_full)
  );
  assign in_ready = ~rst_q & ~skid_full;
`else
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      blk_out   <= '0;
    end else begin
      if (accept) blk_out <= blk_in;
      out_valid <= accept | (out_valid & ~out_ready);
    end
  assign in_ready = ~rst_q & ~out_valid;
`endif
endmodule

// File: tb/tb_add_round_key_stage.sv
// tb_add_round_key_stage: queue-model and directed-vector bench for add_round_key_stage
module tb_add_round_key_stage;
  import aes_pkg::*;
`ifdef ARK_SKID_BUFFER_EN
  localparam int CAP = 2;
  localparam int STREAM_EDGES = 17;
`else
  localparam int CAP = 1;
  localparam int STREAM_EDGES = 32;
`endif
  typedef struct { state_t s; logic [3:0] r; } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_final, err_round;
  state_t in_state = '0, in_key = '0, out_state;
  logic [3:0] in_round = '0, out_round;
  int total = 0, bad = 0, pops = 0, cyc = 0;
  exp_t q[$];
  bit started = 0, rst_prev = 1, err_m = 0;

  add_round_key_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .out_final(out_final), .err_round(err_round)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  // model: a FIFO of expected blocks bounded by the buffer capacity
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      err_m = 0;
      rst_prev = 1;
      started = 1;
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{in_state ^ in_key, in_round});
        if (in_round > 4'd10) err_m = 1;
      end
      rst_prev = 0;
    end
  end

  always @(negedge clk)
    if (started) begin
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(!rst_prev && q.size() < CAP));
      chk("err_round", 128'(err_round), 128'(err_m));
      if (q.size() != 0) begin
        chk("out_state", out_state, q[0].s);
        chk("out_round", 128'(out_round), 128'(q[0].r));
        chk("out_final", 128'(out_final), 128'(q[0].r == 4'd10));
      end
    end

  task automatic send(input state_t s, input state_t k, input logic [3:0] r);
    int n = 0;
    in_state = s; in_key = k; in_round = r; in_valid = 1;
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    state_t bs [3];
    int idx, n, c0, p0;
    bit acc;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_in_ready", 128'(in_ready), 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_out_round", 128'(out_round), 0);
    chk("rst_out_final", 128'(out_final), 0);
    chk("rst_err", 128'(err_round), 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 128'(in_ready), 1);

    send(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0);
    chk("fips_valid", 128'(out_valid), 1);
    chk("fips_state", out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("fips_final", 128'(out_final), 0);
    idle(2);
    send(128'h00112233445566778899aabbccddeeff, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 4'd10);
    chk("r10_state", out_state, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    chk("r10_round", 128'(out_round), 10);
    chk("r10_final", 128'(out_final), 1);
    idle(2);
    send(128'hffffffffffffffffffffffffffffffff, 128'hffffffffffffffffffffffffffffffff, 4'd9);
    chk("r9_state", out_state, 0);
    chk("r9_final", 128'(out_final), 0);
    idle(2);
    chk("err_before", 128'(err_round), 0);
    send(128'h1, 128'h2, 4'd12);
    chk("err_set", 128'(err_round), 1);
    chk("r12_round", 128'(out_round), 12);
    idle(2);
    send(128'h5, 128'h5, 4'd3);
    idle(2);
    chk("err_sticky", 128'(err_round), 1);

    // backpressure: three blocks offered for five cycles while downstream stalls
    bs[0] = 128'ha5a5; bs[1] = 128'h5a5a; bs[2] = 128'hc3c3;
    out_ready = 0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = idx < 3;
      in_state = bs[idx % 3]; in_key = 128'h0101; in_round = 4'(idx + 1);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    chk("bp_accepted", 128'(idx), 128'(CAP));
    chk("bp_stable_state", out_state, 128'ha4a4);
    chk("bp_stable_round", 128'(out_round), 1);
    out_ready = 1;
    p0 = pops;
    n = 0;
    while (idx < 3 && n < 20) begin
      in_valid = 1;
      in_state = bs[idx]; in_key = 128'h0101; in_round = 4'(idx + 1);
      acc = in_ready;
      @(negedge clk);
      if (acc) idx++;
      n++;
    end
    in_valid = 0;
    idle(4);
    chk("bp_drained", 128'(pops - p0), 3);

    c0 = cyc;
    p0 = pops;
    for (int i = 0; i < 16; i++)
      send({4{32'(i) * 32'h01010101}}, {4{32'h1b2c3d4e}}, 4'(i % 11));
    n = 0;
    while (pops - p0 < 16 && n < 100) begin @(negedge clk); n++; end
    chk("stream_count", 128'(pops - p0), 16);
    chk("stream_edges", 128'(cyc - c0), 128'(STREAM_EDGES));

    out_ready = 0;
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_state = 128'(i + 77); in_key = 128'h9; in_round = 4'd4;
      acc = in_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    in_valid = 0;
    chk("rst_fill", 128'(idx), 128'(CAP));
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", 128'(out_valid), 0);
    chk("midrst_ready", 128'(in_ready), 0);
    chk("midrst_err", 128'(err_round), 0);
    rst = 0;
    out_ready = 1;
    p0 = pops;
    @(negedge clk);
    chk("postrst_ready", 128'(in_ready), 1);
    idle(4);
    chk("postrst_no_stale", 128'(pops - p0), 0);
    chk("postrst_valid", 128'(out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 SHALL have parameter: NR, 10, number of the last AES round; legal round tags are 0..NR.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream (column-mix output) block valid.
REQ-005 SHALL have port: in_ready  output  1  stage can accept a block this cycle.
REQ-006 SHALL have port: in_state  input  128  state block [0:127], bit 0 = MSB of byte 0, bytes column-major.
REQ-007 SHALL have port: in_key  input  128  round key, same bit/byte ordering as in_state.
REQ-008 SHALL have port: in_round  input  4  round tag travelling with the block.
REQ-009 SHALL have port: out_valid  output  1  output block valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts the output block.
REQ-011 SHALL have port: out_state  output  128  registered in_state XOR in_key.
REQ-012 SHALL have port: out_round  output  4  registered round tag of the output block.
REQ-013 SHALL have port: out_final  output  1  high when out_round == NR.
REQ-014 SHALL have port: err_round  output  1  sticky flag: a block with in_round > NR was accepted.

Function
REQ-015 Transfer on either side SHALL occur only in a cycle where valid and ready are both high.
REQ-016 An accepted block SHALL appear on out_state exactly one cycle after acceptance when the output register is free (latency 1).
REQ-017 out_state SHALL equal the bitwise XOR of in_state and in_key captured at acceptance; no other transformation.
REQ-018 out_valid SHALL remain high, with out_state/out_round/out_final stable, until out_ready is sampled high.
REQ-019 in_ready SHALL depend only on registered state (no combinational path from out_ready to in_ready).
REQ-020 Simultaneous accept and drain in one cycle SHALL load the new block and retire the old one with no loss or duplication.
REQ-021 A block with in_round > NR SHALL still be processed and passed through unchanged in tag; err_round SHALL set the cycle after acceptance and hold until reset.
REQ-022 Blocks SHALL leave in strict acceptance order.

Reset
REQ-023 While rst is high on a clock edge: out_valid=0, err_round=0, out_state=0, out_round=0, out_final=0, all buffer entries empty.
REQ-024 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after rst deasserts.
REQ-025 Reset mid-transfer SHALL discard all buffered blocks; no partial block SHALL be emitted afterwards.

Configuration
REQ-026 Macro ARK_SKID_BUFFER_EN defined: 2-entry skid buffer; in_ready = not(skid entry full); sustains one block per cycle under continuous out_ready=1; holds up to 2 blocks under backpressure.
REQ-027 Macro undefined: single output register; in_ready = not out_valid; maximum throughput one block per two cycles; REQ-020 then applies to drain only.

Structure
REQ-028 Shared package aes_pkg SHALL hold: 128-bit state type, 4-bit round type, constant AES_NR = 10.
REQ-029 One sub-module ark_skid_buf (2-entry 132-bit skid register) SHALL be instantiated only under ARK_SKID_BUFFER_EN; XOR stays in the top module.

Verification
REQ-030 FIPS-197 vector: in_state=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, round 0 -> out_state=193de3bea0f4e22b9ac68d2ae9f84808 one cycle later, out_final=0.
REQ-031 Round tag 10 with any data -> out_round=10, out_final=1; tag 9 -> out_final=0.
REQ-032 Backpressure: out_ready=0 for 5 cycles with 3 blocks offered -> outputs stable, 2 accepted (EN) or 1 (no EN), then all emitted in order when out_ready=1.
REQ-033 Streaming 16 back-to-back blocks, out_ready=1 -> 16 outputs in 16 cycles (EN) or 32 cycles (no EN), none lost.
REQ-034 in_round=12 accepted -> err_round=1 next cycle, stays 1 through later legal blocks, clears only on rst.
REQ-035 rst asserted with 2 blocks buffered -> next cycle out_valid=0, in_ready=0; after deassert no stale block emitted.
